// File: rtl/edge_delay_meter.sv
// Measures rise/fall propagation delay (in clk cycles) from a stimulus edge to the
// response reaching its expected level; flags timeouts and aborted measurements.
module edge_delay_meter #(
  parameter bit          INVERT   = 1'b1,
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stim,
  input  logic             resp,
  output logic [CNT_W-1:0] rise_dly,
  output logic [CNT_W-1:0] fall_dly,
  output logic             rise_vld,
  output logic             fall_vld,
  output logic             timeout,
  output logic             abort,
  output logic [CNT_W-1:0] abort_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               x_q, x_d;
  logic               stim_q;
  logic [CNT_W-1:0]   rise_dly_q, fall_dly_q, abort_cnt_q;
  logic               rise_vld_q, fall_vld_q, timeout_q, abort_q;

  logic               stim_edge, x_new, start;
  logic               rep_rise, rep_fall, tmo, abt;
  logic [CNT_W-1:0]   rep_val;

  assign stim_edge = stim ^ stim_q;
  assign x_new     = stim ^ INVERT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    rep_rise = 1'b0;
    rep_fall = 1'b0;
    rep_val  = '0;
    tmo      = 1'b0;
    abt      = 1'b0;
    start    = 1'b0;

    case (state_q)
      S_IDLE: start = stim_edge;
      S_WAIT: begin
        if (resp == x_q) begin
          rep_rise = x_q;
          rep_fall = ~x_q;
          rep_val  = cnt_q;
          state_d  = S_IDLE;
          start    = stim_edge;
        end else if (stim_edge) begin
          abt   = 1'b1;
          start = 1'b1;
        end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge (from IDLE, after a completion, or restarting after an abort)
    // is handled once here; a completion and an immediate match cannot coincide
    // because the new expected level is always the opposite of the old one.
    if (start) begin
      x_d = x_new;
      if (resp == x_new) begin
        rep_rise = x_new;
        rep_fall = ~x_new;
        rep_val  = '0;
        state_d  = S_IDLE;
      end else begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= 1'b0;
      stim_q      <= 1'b0;
      rise_dly_q  <= '0;
      fall_dly_q  <= '0;
      rise_vld_q  <= 1'b0;
      fall_vld_q  <= 1'b0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      stim_q     <= stim;
      rise_vld_q <= rep_rise;
      fall_vld_q <= rep_fall;
      timeout_q  <= tmo;
      abort_q    <= abt;
      if (rep_rise) rise_dly_q <= rep_val;
      if (rep_fall) fall_dly_q <= rep_val;
      if (abt && (abort_cnt_q != '1)) abort_cnt_q <= abort_cnt_q + 1'b1;
    end
  end

  assign rise_dly  = rise_dly_q;
  assign fall_dly  = fall_dly_q;
  assign rise_vld  = rise_vld_q;
  assign fall_vld  = fall_vld_q;
  assign timeout   = timeout_q;
  assign abort     = abort_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_edge_delay_meter.sv
// Directed bench for edge_delay_meter: cycle-stamp reference model compared every
// cycle, plus literal expectations for the documented scenarios.
module tb_edge_delay_meter;
  localparam bit          INV  = 1'b1;
  localparam int unsigned MAXW = 16;
  localparam int unsigned W    = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stim = 1'b0;
  logic         resp = 1'b0;
  logic [W-1:0] rise_dly, fall_dly, abort_cnt;
  logic         rise_vld, fall_vld, timeout, abort;

  int checks = 0;
  int errors = 0;

  edge_delay_meter #(.INVERT(INV), .MAX_WAIT(MAXW), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .stim(stim), .resp(resp),
    .rise_dly(rise_dly), .fall_dly(fall_dly),
    .rise_vld(rise_vld), .fall_vld(fall_vld),
    .timeout(timeout), .abort(abort), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the cycle stamp of the pending stim edge and the
  // level resp must reach; delay is the stamp difference.
  logic [W-1:0] m_rise_dly = '0, m_fall_dly = '0, m_abort_cnt = '0;
  bit           m_rise_vld = 0, m_fall_vld = 0, m_timeout = 0, m_abort = 0;
  bit           pend = 0, mexp = 0, prev_stim = 0;
  int           cyc = 0, edge_cyc = 0;

  task automatic mrep(input bit up, input int d);
    if (up) begin m_rise_dly = W'(d); m_rise_vld = 1; end
    else    begin m_fall_dly = W'(d); m_fall_vld = 1; end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_rise_dly = '0; m_fall_dly = '0; m_abort_cnt = '0;
        m_rise_vld = 0; m_fall_vld = 0; m_timeout = 0; m_abort = 0;
        pend = 0; prev_stim = 0; cyc = 0;
      end else begin
        m_rise_vld = 0; m_fall_vld = 0; m_timeout = 0; m_abort = 0;
        if (pend && resp == mexp) begin
          mrep(mexp, cyc - edge_cyc);
          pend = 0;
        end
        if (stim != prev_stim) begin
          if (pend) begin
            m_abort = 1;
            if (m_abort_cnt != '1) m_abort_cnt = m_abort_cnt + 1;
            pend = 0;
          end
          mexp = stim ^ INV;
          edge_cyc = cyc;
          if (resp == mexp) mrep(mexp, 0);
          else pend = 1;
        end else if (pend && (cyc - edge_cyc) == int'(MAXW)) begin
          m_timeout = 1;
          pend = 0;
        end
        prev_stim = stim;
        cyc++;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp rise_dly",  rise_dly,      m_rise_dly);
    chk("cmp fall_dly",  fall_dly,      m_fall_dly);
    chk("cmp rise_vld",  W'(rise_vld),  W'(m_rise_vld));
    chk("cmp fall_vld",  W'(fall_vld),  W'(m_fall_vld));
    chk("cmp timeout",   W'(timeout),   W'(m_timeout));
    chk("cmp abort",     W'(abort),     W'(m_abort));
    chk("cmp abort_cnt", abort_cnt,     m_abort_cnt);
  end

  // Apply inputs just after an edge; return just after the edge that samples them.
  task automatic step(input logic s, input logic r);
    stim = s;
    resp = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " rise_dly"},  rise_dly, '0);
    chk({name, " fall_dly"},  fall_dly, '0);
    chk({name, " pulses"},    W'({rise_vld, fall_vld, timeout, abort}), '0);
    chk({name, " abort_cnt"}, abort_cnt, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    chk_all_zero("idle after reset");

    // Edge with resp already at expected level (X=0): fall 0 immediately.
    step(1'b1, 1'b0);
    chk("s5 fall_vld", W'(fall_vld), 1);
    chk("s5 fall_dly", fall_dly, 0);
    chk("s5 rise_vld", W'(rise_vld), 0);
    step(1'b1, 1'b0);
    chk("s5 fall_vld drop", W'(fall_vld), 0);

    // stim 1->0, resp rises two samples later: rise 2.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("s1 rise_vld", W'(rise_vld), 1);
    chk("s1 rise_dly", rise_dly, 2);
    step(1'b0, 1'b1);
    chk("s1 rise_vld one cycle", W'(rise_vld), 0);

    // stim 0->1, resp falls one sample later: fall 1.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("s2 fall_vld", W'(fall_vld), 1);
    chk("s2 fall_dly", fall_dly, 1);
    chk("s2 rise_dly held", rise_dly, 2);

    // stim 1->0, resp held 0: timeout after MAXW sampled waits.
    step(1'b0, 1'b0);
    repeat (MAXW - 1) step(1'b0, 1'b0);
    chk("s3 no early timeout", W'(timeout), 0);
    step(1'b0, 1'b0);
    chk("s3 timeout", W'(timeout), 1);
    chk("s3 rise_dly held", rise_dly, 2);
    chk("s3 fall_dly held", fall_dly, 1);
    step(1'b0, 1'b0);
    chk("s3 timeout one cycle", W'(timeout), 0);

    // Abort: stim 1->0 then 0->1 with resp 0; new X=0 matches -> fall 0.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("s4 abort", W'(abort), 1);
    chk("s4 abort_cnt", abort_cnt, 1);
    chk("s4 fall_vld", W'(fall_vld), 1);
    chk("s4 fall_dly", fall_dly, 0);

    // Completion and a new edge in the same sample: rise 3, then fall 2.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("cpl+edge rise_dly", rise_dly, 3);
    chk("cpl+edge abort", W'(abort), 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("cpl+edge fall_dly", fall_dly, 2);

    // resp toggling in IDLE without stim edge is ignored.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("idle toggle pulses", W'({rise_vld, fall_vld, timeout, abort}), 0);

    // Async reset mid-WAIT at cnt=5.
    step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("s6 async reset");
    stim = 1'b0;
    resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (MAXW + 4) step(1'b0, 1'b0);
    chk_all_zero("s6 after release");

    step(1'b1, 1'b0);
    chk("post reset fall_vld", W'(fall_vld), 1);
    step(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
